// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit 7-segment scanner with BCD decode, frame-consistent shadow and per-digit blink.
// Latency: ANODE/SEG registered one cycle after scan/shadow/blink state; no backpressure, free-running.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic [15:0] DIGITS,
    input  logic [1:0]  BLNK_INDEX,
    input  logic        BLNK_ENABLE,
    output logic [3:0]  ANODE,
    output logic [6:0]  SEG
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_cnt;
    logic          slot_tick;
    logic [1:0]    scan_idx;
    logic [15:0]   shadow;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [3:0]    digit;
    logic [6:0]    seg_dec;
    logic [3:0]    anode_dec;
    logic          blank;

    assign slot_tick = (refresh_cnt == REFRESH_LAST);

    // Shadow only reloads at the end of slot 3 so a whole frame shows one value.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
            shadow      <= 16'h0000;
        end else if (slot_tick) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 2'd1;
            if (scan_idx == 2'd3) begin
                shadow <= DIGITS;
            end
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // Holding the counter at 0 while disabled guarantees a full visible phase on re-enable.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!BLNK_ENABLE) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_comb begin
        digit     = shadow[{scan_idx, 2'b00} +: 4];
        anode_dec = ~(4'b0001 << scan_idx);
        blank     = BLNK_ENABLE && !blink_phase && (BLNK_INDEX == scan_idx);
        case (digit)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b0111111;
        endcase
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            ANODE <= 4'b1111;
            SEG   <= 7'b1111111;
        end else if (blank) begin
            ANODE <= 4'b1111;
            SEG   <= 7'b1111111;
        end else begin
            ANODE <= anode_dec;
            SEG   <= seg_dec;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4, BLINK_DIV=8; outputs sampled 2 time units after posedge.
module tb_seven_seg_scanner;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    logic        MCLK;
    logic        RESET;
    logic [15:0] DIGITS;
    logic [1:0]  BLNK_INDEX;
    logic        BLNK_ENABLE;
    logic [3:0]  ANODE;
    logic [6:0]  SEG;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          adv;
        logic [15:0] digits;
        logic        en;
        logic [1:0]  bidx;
        logic [3:0]  an;
        logic [6:0]  seg;
    } vec_t;

    vec_t vecs[$];

    seven_seg_scanner #(
        .REFRESH_DIV(4),
        .BLINK_DIV  (8)
    ) dut (
        .MCLK       (MCLK),
        .RESET      (RESET),
        .DIGITS     (DIGITS),
        .BLNK_INDEX (BLNK_INDEX),
        .BLNK_ENABLE(BLNK_ENABLE),
        .ANODE      (ANODE),
        .SEG        (SEG)
    );

    initial begin
        MCLK = 1'b0;
        forever #5 MCLK = ~MCLK;
    end

    task automatic step(input int n);
        repeat (n) @(posedge MCLK);
        #2;
    endtask

    task automatic check(input string name, input logic [3:0] exp_an, input logic [6:0] exp_seg);
        n_cmp++;
        if (ANODE !== exp_an || SEG !== exp_seg) begin
            n_err++;
            $display("FAIL %s: got ANODE=%b SEG=%b, want ANODE=%b SEG=%b", name, ANODE, SEG, exp_an, exp_seg);
        end
    endtask

    task automatic add(input int adv, input logic [15:0] d, input logic en, input logic [1:0] bi,
                       input logic [3:0] an, input logic [6:0] seg);
        vec_t v;
        v.adv = adv; v.digits = d; v.en = en; v.bidx = bi; v.an = an; v.seg = seg;
        vecs.push_back(v);
    endtask

    initial begin
        // Edge numbers in comments count rising edges after reset release.
        add(1, 16'h1259, 0, 0, 4'b1110, S0);  // e1: first output after reset
        add(4, 16'h1259, 0, 0, 4'b1101, S0);  // e5
        add(4, 16'h1259, 0, 0, 4'b1011, S0);  // e9
        add(4, 16'h1259, 0, 0, 4'b0111, S0);  // e13
        add(4, 16'h1259, 0, 0, 4'b1110, S9);  // e17: first loaded frame
        add(3, 16'h1259, 0, 0, 4'b1110, S9);  // e20: end of slot 0
        add(1, 16'h1259, 0, 0, 4'b1101, S5);  // e21
        add(4, 16'h1259, 0, 0, 4'b1011, S2);  // e25
        add(4, 16'h1259, 0, 0, 4'b0111, S1);  // e29
        add(4, 16'h1259, 0, 0, 4'b1110, S9);  // e33
        add(4, 16'h1259, 0, 0, 4'b1101, S5);  // e37: scan index 1
        add(4, 16'h0000, 0, 0, 4'b1011, S2);  // e41: DIGITS changed mid-frame
        add(4, 16'h0000, 0, 0, 4'b0111, S1);  // e45
        add(4, 16'h0000, 0, 0, 4'b1110, S0);  // e49: new frame
        add(4, 16'h0000, 0, 0, 4'b1101, S0);  // e53
        add(4, 16'h0000, 0, 0, 4'b1011, S0);  // e57
        add(4, 16'h0000, 0, 0, 4'b0111, S0);  // e61
        add(4, 16'hFA00, 0, 0, 4'b1110, S0);  // e65
        add(4, 16'hFA00, 0, 0, 4'b1101, S0);  // e69
        add(4, 16'hFA00, 0, 0, 4'b1011, SD);  // e73: code A
        add(4, 16'hFA00, 0, 0, 4'b0111, SD);  // e77: code F
        add(5, 16'hFA00, 0, 2, 4'b1110, S0);  // e82
        add(7, 16'hFA00, 1, 2, 4'b1011, SD);  // e89: blink on since e82, still visible
        add(1, 16'hFA00, 1, 2, 4'b1011, SD);  // e90: eighth visible output
        add(1, 16'hFA00, 1, 2, 4'b1111, SB);  // e91: first blank
        add(1, 16'hFA00, 1, 2, 4'b1111, SB);  // e92
        add(1, 16'hFA00, 1, 2, 4'b0111, SD);  // e93: other slot unaffected
        add(12, 16'hFA00, 1, 2, 4'b1011, SD); // e105: visible phase again
        add(2, 16'hFA00, 1, 2, 4'b1111, SB);  // e107: blank phase
        add(1, 16'hFA00, 1, 3, 4'b1011, SD);  // e108: index moved mid-frame
        add(1, 16'hFA00, 1, 3, 4'b1111, SB);  // e109: slot 3 now blank
        add(1, 16'hFA00, 0, 3, 4'b0111, SD);  // e110: disable during blank
        add(2, 16'hFA00, 1, 3, 4'b0111, SD);  // e112: re-enabled, fresh visible phase
        add(13, 16'hFA00, 1, 3, 4'b1111, SB); // e125: blank 8 outputs after e118
        add(2, 16'hFA00, 1, 3, 4'b0111, SD);  // e127: visible again

        RESET       = 1'b1;
        DIGITS      = 16'h1259;
        BLNK_INDEX  = 2'd0;
        BLNK_ENABLE = 1'b0;
        step(2);
        check("reset_hold", 4'b1111, SB);
        RESET = 1'b0;

        foreach (vecs[i]) begin
            DIGITS      = vecs[i].digits;
            BLNK_ENABLE = vecs[i].en;
            BLNK_INDEX  = vecs[i].bidx;
            step(vecs[i].adv);
            check($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg);
        end

        // Asynchronous reset between clock edges during slot 2.
        BLNK_ENABLE = 1'b0;
        step(11);                                // e138
        check("pre_async_rst", 4'b1011, SD);
        #1 RESET = 1'b1;
        #1 check("async_rst_now", 4'b1111, SB);
        step(2);
        check("async_rst_held", 4'b1111, SB);
        RESET = 1'b0;
        step(1);
        check("rst_release_e1", 4'b1110, S0);
        step(4);
        check("rst_release_e5", 4'b1101, S0);
        step(4);
        check("shadow_cleared", 4'b1011, S0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named MCLK and RESET.
REQ-002 Parameter REFRESH_DIV, default 100000, SHALL set the MCLK cycles per digit slot (1 kHz slot rate at 100 MHz).
REQ-003 Parameter BLINK_DIV, default 50000000, SHALL set the MCLK cycles per blink half-period (0.5 s at 100 MHz).
REQ-004 MCLK  input  1  board clock; all state is updated on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 DIGITS  input  16  BCD digits {d3,d2,d1,d0}; d3 is leftmost (min10), d0 is rightmost (sec01).
REQ-007 BLNK_INDEX  input  2  digit position to blink (0 = d0 ... 3 = d3).
REQ-008 BLNK_ENABLE  input  1  1 = the digit at BLNK_INDEX blinks.
REQ-009 ANODE  output  4  active-low digit enables; ANODE[k] drives position k.
REQ-010 SEG  output  7  active-low segments {g,f,e,d,c,b,a}.

Function
REQ-011 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; a slot tick SHALL be asserted for exactly one cycle when the counter equals REFRESH_DIV-1.
REQ-012 The 2-bit scan index SHALL advance by 1 on each slot tick, in the order 0,1,2,3,0.
REQ-013 A 16-bit shadow register SHALL load DIGITS only on a slot tick where the scan index is 3 (frame boundary), so each frame shows one consistent value.
REQ-014 The blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase at wrap; while BLNK_ENABLE=0, the counter SHALL be held at 0 and blink_phase held at 1 (visible).
REQ-015 On the first cycle with BLNK_ENABLE=1, the digit SHALL be visible for a full BLINK_DIV cycles before its first blank phase.
REQ-016 ANODE and SEG SHALL be registered, one cycle of latency from the scan index, shadow, and blink_phase values.
REQ-017 ANODE SHALL be the one-cold vector for the scan index (idx 0 -> 4'b1110, idx 3 -> 4'b0111).
REQ-018 If BLNK_ENABLE=1, blink_phase=0, and BLNK_INDEX equals the scan index, ANODE SHALL be 4'b1111 and SEG SHALL be 7'b1111111.
REQ-019 The BCD decode SHALL be 0 -> 7'b1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000, 4 -> 0011001, 5 -> 0010010, 6 -> 0000010, 7 -> 1111000, 8 -> 0000000, 9 -> 0010000.
REQ-020 Codes 10-15 SHALL decode to a dash, 7'b0111111 (g only).
REQ-021 A change to BLNK_INDEX mid-frame SHALL take effect on the next registered output, with no wait for the frame boundary.
REQ-022 A change to DIGITS mid-frame SHALL NOT affect SEG until after the next frame boundary load.

Reset
REQ-023 While RESET=1, ANODE SHALL be 4'b1111 and SEG SHALL be 7'b1111111.
REQ-024 While RESET=1, the refresh counter, scan index, blink counter, and shadow SHALL be 0 and blink_phase SHALL be 1.
REQ-025 Reset asserted mid-slot or mid-frame SHALL clear all state immediately, without waiting for a clock edge.
REQ-026 On the first clock edge after RESET deasserts, ANODE SHALL be 4'b1110 and SEG SHALL be 7'b1000000 (shadow is 0 until the first frame load).

Verification
REQ-027 Test: REFRESH_DIV=4, DIGITS=16'h1259, BLNK_ENABLE=0, reset released -> ANODE cycles 1110,1101,1011,0111 every 4 clocks; SEG shows "0" for the first frame, then 0010000, 0010010, 0100100, 1111001 (9,5,2,1).
REQ-028 Test: change DIGITS from 16'h1259 to 16'h0000 during scan index 1 -> the remaining slots of the current frame still show 2 and 1; the next frame shows 0 on all digits.
REQ-029 Test: BLINK_DIV=8, BLNK_INDEX=2, raise BLNK_ENABLE -> slot 2 is visible for the first 8 clocks, then ANODE=1111 and SEG=1111111 during slot 2 for 8 clocks, alternating after that; other slots are unaffected.
REQ-030 Test: DIGITS=16'hFA00 -> positions 3 and 2 show 0111111, positions 1 and 0 show 1000000.
REQ-031 Test: assert RESET asynchronously between clock edges during slot 2 -> ANODE=1111 and SEG=1111111 at once; after release, the scan restarts at idx 0.
REQ-032 Test: drop BLNK_ENABLE during a blank phase -> the digit is visible on the next registered output, and re-enabling restarts with a full visible phase.
